// File: rtl/sy_ppl_exu_iq_gen.sv
// Age-ordered, compressed issue queue with a generic payload.
// Valid entries live in slots 0..cnt-1 with slot 0 the oldest; issue picks the oldest
// entry whose sources are all ready, and younger entries shift down to close the gap.
module sy_ppl_exu_iq_gen #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SRC_NUM   = 3,
  parameter int unsigned WAKE_NUM  = 5,
  parameter int unsigned TAG_W     = 7,
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      enq_vld_i,
  output logic                      enq_rdy_o,
  input  logic [PAYLOAD_W-1:0]      enq_payload_i,
  input  logic [SRC_NUM*TAG_W-1:0]  enq_src_idx_i,
  input  logic [SRC_NUM-1:0]        enq_src_fp_i,
  input  logic [SRC_NUM-1:0]        enq_src_rdy_i,
  output logic                      iss_vld_o,
  input  logic                      iss_rdy_i,
  output logic [PAYLOAD_W-1:0]      iss_payload_o,
  input  logic [WAKE_NUM-1:0]       wk_vld_i,
  input  logic [WAKE_NUM*TAG_W-1:0] wk_idx_i,
  input  logic [WAKE_NUM-1:0]       wk_is_fp_i,
  output logic [CNT_W-1:0]          cnt_o
);

  localparam int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PAYLOAD_W-1:0]            r_pay [DEPTH];
  logic [SRC_NUM-1:0][TAG_W-1:0]   r_tag [DEPTH];
  logic [SRC_NUM-1:0]              r_fp  [DEPTH];
  logic [SRC_NUM-1:0]              r_rdy [DEPTH];
  logic [CNT_W-1:0]                r_cnt;

  logic [PAYLOAD_W-1:0]            w_pay_nxt [DEPTH];
  logic [SRC_NUM-1:0][TAG_W-1:0]   w_tag_nxt [DEPTH];
  logic [SRC_NUM-1:0]              w_fp_nxt  [DEPTH];
  logic [SRC_NUM-1:0]              w_rdy_nxt [DEPTH];
  logic [SRC_NUM-1:0]              w_rdy_upd [DEPTH];
  logic [SRC_NUM-1:0]              w_enq_rdy_bits;
  logic [CNT_W-1:0]                w_cnt_nxt;
  logic [CNT_W-1:0]                w_wr_slot;
  logic [SEL_W-1:0]                w_sel;
  logic                            w_any;
  logic                            w_enq_fire;
  logic                            w_deq;

  function automatic logic f_wake_hit(input logic [TAG_W-1:0]          tag,
                                      input logic                      fp,
                                      input logic [WAKE_NUM-1:0]       vld,
                                      input logic [WAKE_NUM*TAG_W-1:0] idx,
                                      input logic [WAKE_NUM-1:0]       is_fp);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_NUM; p++) begin
      hit = hit | (vld[p] && (idx[p*TAG_W +: TAG_W] == tag) && (is_fp[p] == fp));
    end
    return hit;
  endfunction

  // Apply this cycle's wakeups to live slots and to the incoming entry (bypass)
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < SRC_NUM; k++) begin
        // Dead slots are forced to 0 so a stray tag match cannot mark them ready
        w_rdy_upd[i][k] = (CNT_W'(i) < r_cnt) &&
                          (r_rdy[i][k] ||
                           f_wake_hit(r_tag[i][k], r_fp[i][k], wk_vld_i, wk_idx_i, wk_is_fp_i));
      end
    end
    for (int k = 0; k < SRC_NUM; k++) begin
      w_enq_rdy_bits[k] = enq_src_rdy_i[k] ||
                          f_wake_hit(enq_src_idx_i[k*TAG_W +: TAG_W], enq_src_fp_i[k],
                                     wk_vld_i, wk_idx_i, wk_is_fp_i);
    end
  end

  // Oldest-first select from registered ready bits only
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_any && (CNT_W'(i) < r_cnt) && (&r_rdy[i])) begin
        w_sel = SEL_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign enq_rdy_o     = (r_cnt < CNT_W'(DEPTH));
  assign w_enq_fire    = enq_vld_i && enq_rdy_o && !flush_i;
  assign iss_vld_o     = w_any && !flush_i;
  assign iss_payload_o = r_pay[w_sel];
  assign w_deq         = iss_vld_o && iss_rdy_i;
  assign w_wr_slot     = w_deq ? (r_cnt - CNT_W'(1)) : r_cnt;
  assign cnt_o         = r_cnt;

  // Next-state: compress on dequeue, then append the new entry at the tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_pay_nxt[i] = r_pay[i];
      w_tag_nxt[i] = r_tag[i];
      w_fp_nxt[i]  = r_fp[i];
      w_rdy_nxt[i] = w_rdy_upd[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (w_deq && (CNT_W'(i) >= CNT_W'(w_sel)) && (CNT_W'(i) < r_cnt - CNT_W'(1))) begin
        w_pay_nxt[i] = r_pay[i+1];
        w_tag_nxt[i] = r_tag[i+1];
        w_fp_nxt[i]  = r_fp[i+1];
        w_rdy_nxt[i] = w_rdy_upd[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_deq && (CNT_W'(i) == r_cnt - CNT_W'(1))) begin
        w_pay_nxt[i] = '0;
        w_tag_nxt[i] = '0;
        w_fp_nxt[i]  = '0;
        w_rdy_nxt[i] = '0;
      end
      if (w_enq_fire && (CNT_W'(i) == w_wr_slot)) begin
        w_pay_nxt[i] = enq_payload_i;
        w_tag_nxt[i] = enq_src_idx_i;
        w_fp_nxt[i]  = enq_src_fp_i;
        w_rdy_nxt[i] = w_enq_rdy_bits;
      end
    end
    case ({w_enq_fire, w_deq})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // State registers; flush empties the queue but leaves payloads stale
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pay[i] <= '0;
        r_tag[i] <= '0;
        r_fp[i]  <= '0;
        r_rdy[i] <= '0;
      end
    end else if (flush_i) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rdy[i] <= '0;
      end
    end else begin
      r_cnt <= w_cnt_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_pay[i] <= w_pay_nxt[i];
        r_tag[i] <= w_tag_nxt[i];
        r_fp[i]  <= w_fp_nxt[i];
        r_rdy[i] <= w_rdy_nxt[i];
      end
    end
  end

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) r_cnt <= CNT_W'(DEPTH));
  a_no_enq_full: assert property (@(posedge clk_i) disable iff (rst_i)
                                  !(w_enq_fire && (r_cnt == CNT_W'(DEPTH))));
  a_iss_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
                                   iss_vld_o |-> (r_cnt != '0));

endmodule
